// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - states, opcodes and select codes for the multicycle control unit
package multicycle_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_FETCH, ST_DECODE, ST_RTYPE, ST_RWRITE, ST_MEMADDR, ST_LW1, ST_LW2, ST_SW,
    ST_IMM, ST_IMM2, ST_JAL1, ST_JAL2, ST_JR, ST_JUMP, ST_BEQ, ST_BNE,
    ST_IN, ST_OUT, ST_TRAP
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_ORI   = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;
  localparam logic [3:0] OP_J     = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_JR    = 4'd11;
  localparam logic [3:0] OP_IO    = 4'd12;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;

  localparam logic [1:0] PCSRC_ALU  = 2'd0;
  localparam logic [1:0] PCSRC_JUMP = 2'd1;
  localparam logic [1:0] PCSRC_TRAP = 2'd2;

  localparam logic [1:0] MTR_MEM = 2'd0;
  localparam logic [1:0] MTR_ALU = 2'd1;
  localparam logic [1:0] MTR_IN  = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // First execute state for an opcode; anything unlisted traps.
  function automatic state_t decode_target(input logic [3:0] op, input logic io_in);
    case (op)
      OP_RTYPE:                 decode_target = ST_RTYPE;
      OP_ADDI, OP_ORI, OP_ANDI: decode_target = ST_IMM;
      OP_LW, OP_SW:             decode_target = ST_MEMADDR;
      OP_BEQ:                   decode_target = ST_BEQ;
      OP_BNE:                   decode_target = ST_BNE;
      OP_J:                     decode_target = ST_JUMP;
      OP_JAL:                   decode_target = ST_JAL1;
      OP_JR:                    decode_target = ST_JR;
      OP_IO:                    decode_target = io_in ? ST_IN : ST_OUT;
      default:                  decode_target = ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_v2_wait_timer.sv
// rtl/multicycle_control_v2_wait_timer.sv - saturating count of consecutive stalled cycles
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the stalled cycle that brings the count up to LIMIT.
  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = waiting && (count == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_v2.sv
// rtl/multicycle_control_v2.sv - multicycle control FSM with wait-state handshakes, timeout and trap
module multicycle_control_v2
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int FUNCT_W     = 3,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic                MemReady,
  input  logic                InValid,
  input  logic                OutReady,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSrc,
  output logic                SrcA,
  output logic [1:0]          SrcB,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          RegDest,
  output logic                MemSrc,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchCond,
  output logic                OutputWrite,
  output logic                InReady,
  output logic                Trap,
  output logic [1:0]          TrapCause,
  output logic [4:0]          State
);

  state_t     state, state_next;
  logic [1:0] cause;
  logic       wait_state, handshake, waiting, expired, hi_zero;
  logic [3:0] op4;

  assign op4       = Opcode[3:0];
  assign hi_zero   = ((Opcode >> 4) == '0);
  assign State     = state;
  assign TrapCause = cause;

  always_comb begin
    wait_state = 1'b1;
    handshake  = 1'b1;
    case (state)
      ST_FETCH, ST_LW1, ST_SW: handshake = MemReady;
      ST_IN:                   handshake = InValid;
      ST_OUT:                  handshake = OutReady;
      default:                 wait_state = 1'b0;
    endcase
    waiting = wait_state && !handshake;
  end

  wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (Reset),
    .clear  (state_next != state),
    .waiting(waiting),
    .expired(expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   if (MemReady) state_next = ST_DECODE;
      ST_DECODE:  state_next = hi_zero ? decode_target(op4, Funct == FUNCT_W'(1)) : ST_TRAP;
      ST_RTYPE:   state_next = ST_RWRITE;
      ST_MEMADDR: state_next = (op4 == OP_LW) ? ST_LW1 : ST_SW;
      ST_LW1:     if (MemReady) state_next = ST_LW2;
      ST_SW:      if (MemReady) state_next = ST_FETCH;
      ST_IMM:     state_next = ST_IMM2;
      ST_JAL1:    state_next = ST_JAL2;
      ST_IN:      if (InValid) state_next = ST_FETCH;
      ST_OUT:     if (OutReady) state_next = ST_FETCH;
      default:    state_next = ST_FETCH;
    endcase
    if (expired) state_next = ST_TRAP;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= ST_FETCH;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if (state_next == ST_TRAP && state != ST_TRAP) begin
        cause <= expired ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
      end
    end
  end

  always_comb begin
    ALUOp       = ALUOP_W'(ALU_AND);
    PCSrc       = PCSRC_ALU;
    SrcA        = 1'b0;
    SrcB        = 2'd0;
    MemtoReg    = MTR_MEM;
    RegDest     = RD_RT;
    MemSrc      = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchCond  = 1'b0;
    OutputWrite = 1'b0;
    InReady     = 1'b0;
    Trap        = 1'b0;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        SrcB    = 2'd1;
        ALUOp   = ALUOP_W'(ALU_ADD);
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      ST_DECODE: begin
        SrcA  = 1'b1;
        ALUOp = ALUOP_W'(ALU_ADD);
      end
      ST_RTYPE: begin
        SrcA  = 1'b1;
        ALUOp = ALUOP_W'(Funct);
      end
      ST_RWRITE: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_ALU;
        RegDest  = RD_RD;
      end
      ST_MEMADDR: begin
        SrcA  = 1'b1;
        SrcB  = 2'd2;
        ALUOp = ALUOP_W'(ALU_ADD);
      end
      ST_LW1: begin
        MemRead = 1'b1;
        MemSrc  = 1'b1;
      end
      ST_LW2: begin
        RegWrite = 1'b1;
      end
      ST_SW: begin
        MemSrc   = 1'b1;
        MemWrite = MemReady;
      end
      ST_IMM: begin
        SrcA = 1'b1;
        SrcB = 2'd2;
        case (op4)
          OP_ORI:  ALUOp = ALUOP_W'(ALU_OR);
          OP_ANDI: ALUOp = ALUOP_W'(ALU_AND);
          default: ALUOp = ALUOP_W'(ALU_ADD);
        endcase
      end
      ST_IMM2: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_ALU;
      end
      ST_JAL1: begin
        SrcB  = 2'd1;
        ALUOp = ALUOP_W'(ALU_ADD);
      end
      ST_JAL2: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_ALU;
        RegDest  = RD_RA;
        PCWrite  = 1'b1;
        PCSrc    = PCSRC_JUMP;
      end
      ST_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      ST_JR: begin
        SrcA    = 1'b1;
        ALUOp   = ALUOP_W'(ALU_ADD);
        PCWrite = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        SrcA        = 1'b1;
        ALUOp       = ALUOP_W'(ALU_SUB);
        PCWriteCond = 1'b1;
        BranchCond  = (state == ST_BEQ);
      end
      ST_IN: begin
        InReady  = 1'b1;
        RegWrite = InValid;
        MemtoReg = MTR_IN;
        RegDest  = RD_RD;
      end
      ST_OUT: begin
        OutputWrite = OutReady;
      end
      ST_TRAP: begin
        Trap    = 1'b1;
        PCWrite = 1'b1;
        PCSrc   = PCSRC_TRAP;
      end
      default: ;
    endcase
    // Nothing may fire while held in reset or on the cycle a stall times out.
    if (!Reset || expired) begin
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchCond  = 1'b0;
      OutputWrite = 1'b0;
      InReady     = 1'b0;
      Trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb/tb_multicycle_control_v2.sv - randomized bench against an instruction-sequence model
module tb_multicycle_control_v2;
  import multicycle_ctrl_pkg::*;

  localparam int T = 4;
  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_SUB = 3'd3;
  localparam logic [12:0] C_ALU = 13'h1C00, C_PCS = 13'h0300, C_SA = 13'h0080, C_SB = 13'h0060;
  localparam logic [12:0] C_M2R = 13'h0018, C_RD = 13'h0006, C_MS = 13'h0001;

  logic       CLK = 1'b0, Reset = 1'b0;
  logic [3:0] Opcode = '0;
  logic [2:0] Funct = '0;
  logic       MemReady = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc, SrcB, MemtoReg, RegDest, TrapCause;
  logic       SrcA, MemSrc, RegWrite, MemRead, MemWrite, IRWrite, PCWrite;
  logic       PCWriteCond, BranchCond, OutputWrite, InReady, Trap;
  logic [4:0] State;

  multicycle_control_v2 #(.OPCODE_W(4), .FUNCT_W(3), .ALUOP_W(3), .MEM_TIMEOUT(T)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .InValid(InValid), .OutReady(OutReady), .ALUOp(ALUOp), .PCSrc(PCSrc), .SrcA(SrcA),
    .SrcB(SrcB), .MemtoReg(MemtoReg), .RegDest(RegDest), .MemSrc(MemSrc),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchCond(BranchCond),
    .OutputWrite(OutputWrite), .InReady(InReady), .Trap(Trap), .TrapCause(TrapCause),
    .State(State)
  );

  always #5 CLK = ~CLK;

  int         tests = 0, fails = 0;
  state_t     seq[$];
  int         idx, waits;
  logic [1:0] m_cause;
  logic       need_new, stall;
  logic [6:0] pend[$];
  logic [9:0] cen;
  logic [12:0] csel;
  logic [4:0] cst;
  logic [1:0] ccause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] en_now();
    return {RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchCond,
            OutputWrite, InReady, Trap};
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_LW1) || (s == ST_SW) || (s == ST_IN) || (s == ST_OUT);
  endfunction

  function automatic logic hs_of(input state_t s, input logic mr, input logic iv, input logic ordy);
    if (s == ST_IN) return iv;
    if (s == ST_OUT) return ordy;
    return mr;
  endfunction

  // Full state walk of one instruction when nothing stalls.
  function automatic void build(input logic [3:0] op, input logic [2:0] fn);
    seq.delete();
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (op)
      4'd0:             begin seq.push_back(ST_RTYPE); seq.push_back(ST_RWRITE); end
      4'd1, 4'd4, 4'd5: begin seq.push_back(ST_IMM); seq.push_back(ST_IMM2); end
      4'd2:             begin seq.push_back(ST_MEMADDR); seq.push_back(ST_LW1); seq.push_back(ST_LW2); end
      4'd3:             begin seq.push_back(ST_MEMADDR); seq.push_back(ST_SW); end
      4'd7:             seq.push_back(ST_BEQ);
      4'd8:             seq.push_back(ST_BNE);
      4'd9:             seq.push_back(ST_JUMP);
      4'd10:            begin seq.push_back(ST_JAL1); seq.push_back(ST_JAL2); end
      4'd11:            seq.push_back(ST_JR);
      4'd12:            seq.push_back(fn == 3'd1 ? ST_IN : ST_OUT);
      default:          seq.push_back(ST_TRAP);
    endcase
    idx = 0;
    waits = 0;
  endfunction

  function automatic void expect_out(input state_t s, input logic [3:0] op, input logic [2:0] fn,
      input logic mr, input logic iv, input logic ordy, input logic to,
      output logic [9:0] en, output logic [12:0] sel, output logic [12:0] care);
    logic rw, mrd, mwr, irw, pcw, pcc, bc, ow, ir, tr, sa, ms;
    logic [2:0] alu;
    logic [1:0] pcs, sb, m2r, rd;
    {rw, mrd, mwr, irw, pcw, pcc, bc, ow, ir, tr} = '0;
    alu = '0; pcs = '0; sb = '0; m2r = '0; rd = '0; sa = 1'b0; ms = 1'b0; care = '0;
    case (s)
      ST_FETCH:   begin mrd = 1; sb = 1; alu = A_ADD; irw = mr; pcw = mr; care = C_MS | C_SA | C_SB | C_ALU | C_PCS; end
      ST_DECODE:  begin sa = 1; alu = A_ADD; care = C_SA | C_SB | C_ALU; end
      ST_RTYPE:   begin sa = 1; alu = fn; care = C_SA | C_SB | C_ALU; end
      ST_RWRITE:  begin rw = 1; m2r = 1; rd = 1; care = C_M2R | C_RD; end
      ST_MEMADDR: begin sa = 1; sb = 2; alu = A_ADD; care = C_SA | C_SB | C_ALU; end
      ST_LW1:     begin mrd = 1; ms = 1; care = C_MS; end
      ST_LW2:     begin rw = 1; care = C_M2R | C_RD; end
      ST_SW:      begin ms = 1; mwr = mr; care = C_MS; end
      ST_IMM:     begin sa = 1; sb = 2; alu = (op == 4'd4) ? A_OR : (op == 4'd5) ? A_AND : A_ADD; care = C_SA | C_SB | C_ALU; end
      ST_IMM2:    begin rw = 1; m2r = 1; care = C_M2R | C_RD; end
      ST_JAL1:    begin sb = 1; alu = A_ADD; care = C_SA | C_SB | C_ALU; end
      ST_JAL2:    begin rw = 1; m2r = 1; rd = 3; pcw = 1; pcs = 1; care = C_M2R | C_RD | C_PCS; end
      ST_JUMP:    begin pcw = 1; pcs = 1; care = C_PCS; end
      ST_JR:      begin sa = 1; alu = A_ADD; pcw = 1; care = C_SA | C_SB | C_ALU | C_PCS; end
      ST_BEQ:     begin sa = 1; alu = A_SUB; pcc = 1; bc = 1; care = C_SA | C_SB | C_ALU; end
      ST_BNE:     begin sa = 1; alu = A_SUB; pcc = 1; care = C_SA | C_SB | C_ALU; end
      ST_IN:      begin ir = 1; rw = iv; m2r = 2; rd = 1; care = C_M2R | C_RD; end
      ST_OUT:     ow = ordy;
      ST_TRAP:    begin tr = 1; pcw = 1; pcs = 2; care = C_PCS; end
      default: ;
    endcase
    en  = to ? 10'd0 : {rw, mrd, mwr, irw, pcw, pcc, bc, ow, ir, tr};
    sel = {alu, pcs, sa, sb, m2r, rd, ms};
  endfunction

  function automatic void model_reset();
    seq.delete();
    idx = 0;
    waits = 0;
    m_cause = 2'd0;
    need_new = 1'b1;
  endfunction

  // One clock: drive at negedge, compare at negedge+1, advance the model at posedge.
  task automatic step(input bit rnd, input logic mr, input logic iv, input logic ordy);
    state_t cur;
    logic hs, to;
    logic [9:0] een;
    logic [12:0] esel, care;
    logic [6:0] nx;
    @(negedge CLK);
    if (need_new) begin
      if (pend.size() > 0) nx = pend.pop_front();
      else nx = 7'($urandom_range(0, 127));
      Funct = nx[6:4];
      Opcode = nx[3:0];
      build(Opcode, Funct);
      stall = ($urandom_range(0, 7) == 0);
      need_new = 1'b0;
    end
    if (rnd) begin
      MemReady = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      InValid  = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      OutReady = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
    end else begin
      MemReady = mr;
      InValid = iv;
      OutReady = ordy;
    end
    #1;
    cur = seq[idx];
    hs = hs_of(cur, MemReady, InValid, OutReady);
    to = is_wait(cur) && !hs && (waits + 1 == T);
    expect_out(cur, Opcode, Funct, MemReady, InValid, OutReady, to, een, esel, care);
    cen = en_now();
    csel = {ALUOp, PCSrc, SrcA, SrcB, MemtoReg, RegDest, MemSrc};
    cst = State;
    ccause = TrapCause;
    chk("state", 32'(cst), 32'(cur));
    chk("enables", 32'(cen), 32'(een));
    chk("selects", 32'(csel & care), 32'(esel & care));
    chk("trap_cause", 32'(ccause), 32'(m_cause));
    @(posedge CLK);
    if (is_wait(cur) && !hs) begin
      if (to) begin
        seq.delete();
        seq.push_back(ST_TRAP);
        idx = 0;
        waits = 0;
        m_cause = 2'd2;
      end else begin
        waits++;
      end
    end else begin
      idx++;
      waits = 0;
      if (idx < seq.size() && seq[idx] == ST_TRAP) m_cause = 2'd1;
    end
    if (idx >= seq.size()) need_new = 1'b1;
  endtask

  initial begin
    state_t ea[4];
    int n_lw1, n_ir, n_rw;
    model_reset();
    MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_enables", 32'(en_now()), 32'd0);
    chk("reset_cause", 32'(TrapCause), 32'd0);
    @(posedge CLK);
    #2 Reset = 1'b1;

    // addi, zero wait
    pend.push_back({3'd0, 4'd1});
    ea = '{ST_FETCH, ST_DECODE, ST_IMM, ST_IMM2};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1);
      if (i == 0) chk("first_memread", 32'(cen[8]), 32'd1);
      chk("addi_state", 32'(cst), 32'(ea[i]));
      chk("addi_regwrite", 32'(cen[9]), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("addi_regdest", 32'(csel[2:1]), 32'd0);

    // lw with three stalled LW1 cycles
    pend.push_back({3'd0, 4'd2});
    n_lw1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, (i < 3 || i == 6) ? 1'b1 : 1'b0, 1, 1);
      if (cst == 5'(ST_LW1)) n_lw1++;
    end
    chk("lw1_cycles", 32'(n_lw1), 32'd4);
    chk("lw2_state", 32'(cst), 32'(ST_LW2));
    chk("lw2_regwrite", 32'(cen[9]), 32'd1);
    chk("lw2_memtoreg", 32'(csel[4:3]), 32'd0);

    // FETCH stuck until timeout, then illegal opcode 13, then bne
    pend.push_back({3'd0, 4'd9});
    pend.push_back({3'd0, 4'd13});
    pend.push_back({3'd0, 4'd8});
    repeat (4) step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("to_state", 32'(cst), 32'(ST_TRAP));
    chk("to_trap", 32'(cen[0]), 32'd1);
    chk("to_pcsrc", 32'(csel[9:8]), 32'd2);
    chk("to_pcwrite", 32'(cen[5]), 32'd1);
    step(0, 1, 1, 1);
    chk("to_cause", 32'(ccause), 32'd2);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    chk("illegal_state", 32'(cst), 32'(ST_TRAP));
    step(0, 1, 1, 1);
    chk("illegal_cause", 32'(ccause), 32'd1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    chk("bne_state", 32'(cst), 32'(ST_BNE));
    chk("bne_pcwritecond", 32'(cen[4]), 32'd1);
    chk("bne_branchcond", 32'(cen[3]), 32'd0);
    chk("bne_pcwrite", 32'(cen[5]), 32'd0);

    // input port, InValid late by two cycles
    pend.push_back({3'd1, 4'd12});
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    n_ir = 0;
    n_rw = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, (i == 2) ? 1'b1 : 1'b0, 1);
      n_ir += int'(cen[1]);
      n_rw += int'(cen[9]);
    end
    chk("in_inready", 32'(n_ir), 32'd3);
    chk("in_regwrite_pulses", 32'(n_rw), 32'd1);
    chk("in_memtoreg", 32'(csel[4:3]), 32'd2);

    // reset while LW1 is stalled
    pend.push_back({3'd0, 4'd2});
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    #2 Reset = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("midreset_state", 32'(State), 32'd0);
    chk("midreset_enables", 32'(en_now()), 32'd0);
    @(posedge CLK);
    #1;
    chk("midreset_hold_enables", 32'(en_now()), 32'd0);
    #1 Reset = 1'b1;
    model_reset();
    step(0, 0, 0, 0);
    chk("release_memread", 32'(cen[8]), 32'd1);
    chk("release_state", 32'(cst), 32'd0);

    repeat (3000) step(1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
